// File: rtl/down_counter_if.sv
// Handshake bundle for the loadable down-counter: control and load value in, count and status out.
// The master drives the controls and the load value; the slave is the counter.
interface down_counter_if #(
    parameter int WIDTH = 5
);
    logic             load;
    logic             enab;
    logic             reload_en;
    logic [WIDTH-1:0] cnt_in;
    logic [WIDTH-1:0] cnt_out;
    logic             tc;
    logic             busy;

    modport master (
        output load, enab, reload_en, cnt_in,
        input  cnt_out, tc, busy
    );

    modport slave (
        input  load, enab, reload_en, cnt_in,
        output cnt_out, tc, busy
    );
endinterface

// File: rtl/down_counter.sv
// Loadable down-counter/timer for stall and multi-cycle countdowns.
// Counts a loaded value down to zero, pulses tc at terminal count and can auto-reload.
module down_counter #(
    parameter int WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    down_counter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload_val;
    logic             tc_q;

    // NOTE: state is updated with non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_val <= '0;
            tc_q       <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus.load) begin
                count      <= bus.cnt_in;
                reload_val <= bus.cnt_in;
                state      <= (bus.cnt_in != '0) ? RUN : IDLE;
            end else if (state == RUN && bus.enab) begin
                if (count > WIDTH'(1)) begin
                    count <= count - WIDTH'(1);
                end else if (count == WIDTH'(1)) begin
                    tc_q <= 1'b1;
                    if (bus.reload_en) begin
                        count <= reload_val;
                    end else begin
                        count <= '0;
                        state <= DONE;
                    end
                end
            end
        end
    end

    assign bus.cnt_out = count;
    assign bus.tc      = tc_q;
    assign bus.busy    = (state == RUN);
endmodule
